// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// State encoding, one-hot grant values and the abort read-data pattern.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_M0 = 2'd1,
        BUSY_M1 = 2'd2
    } state_t;

    localparam logic [1:0]  GRANT_NONE    = 2'b00;
    localparam logic [1:0]  GRANT_M0      = 2'b01;
    localparam logic [1:0]  GRANT_M1      = 2'b10;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;
    localparam int          CNT_W         = 16;

endpackage

// File: rtl/bus_arbiter_timeout_counter.sv
// Busy-cycle counter for the arbiter: clears while idle, counts stalled
// cycles and flags the last cycle before a transfer is aborted.
module arb_timeout_counter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master / one-slave bus arbiter with hung-transfer timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break instead of M0 priority.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    output logic                  m0_ack,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    output logic                  m1_ack,
    output logic [31:0]           m_rdata,
    output logic                  s_req,
    output logic                  s_we,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [31:0]           s_wdata,
    input  logic [31:0]           s_rdata,
    input  logic                  s_ack,
    output logic [1:0]            grant,
    output logic                  timeout
);

    state_t                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  timeout_q, timeout_d;
    logic                  busy;
    logic                  tc;
    logic                  pick_m1;
    logic                  cur_req;
    logic                  cur_we;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [31:0]           cur_wdata;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_m1_q, last_m1_d;

    // On a tie, the master that did not own the bus last time wins.
    assign pick_m1   = m1_req && (!m0_req || !last_m1_q);
    assign last_m1_d = (state_q == IDLE && state_d != IDLE) ?
                       (state_d == BUSY_M1) : last_m1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_m1_q <= 1'b1;
        end else begin
            last_m1_q <= last_m1_d;
        end
    end
`else
    assign pick_m1 = m1_req && !m0_req;
`endif

    assign busy      = (state_q != IDLE);
    assign cur_req   = (state_q == BUSY_M1) ? m1_req   : m0_req;
    assign cur_we    = (state_q == BUSY_M1) ? m1_we    : m0_we;
    assign cur_addr  = (state_q == BUSY_M1) ? m1_addr  : m0_addr;
    assign cur_wdata = (state_q == BUSY_M1) ? m1_wdata : m0_wdata;

    arb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk  (clk),
        .reset(reset),
        .clr_i(!busy),
        .en_i (busy && !s_ack),
        .tc_o (tc)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        timeout_d = timeout_q;
        s_req     = 1'b0;
        s_we      = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m_rdata   = '0;
        case (state_q)
            IDLE: begin
                if (pick_m1) begin
                    state_d = BUSY_M1;
                    grant_d = GRANT_M1;
                end else if (m0_req) begin
                    state_d = BUSY_M0;
                    grant_d = GRANT_M0;
                end
            end
            BUSY_M0, BUSY_M1: begin
                if (!cur_req) begin
                    // Owner withdrew: abandon quietly, any late s_ack is ignored.
                    state_d = IDLE;
                    grant_d = GRANT_NONE;
                end else begin
                    s_req   = 1'b1;
                    s_we    = cur_we;
                    s_addr  = cur_addr;
                    s_wdata = cur_wdata;
                    if (s_ack || tc) begin
                        m0_ack  = (state_q == BUSY_M0);
                        m1_ack  = (state_q == BUSY_M1);
                        m_rdata = s_ack ? s_rdata : TIMEOUT_RDATA;
                        if (!s_ack) begin
                            timeout_d = 1'b1;
                        end
                        state_d = IDLE;
                        grant_d = GRANT_NONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = GRANT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= GRANT_NONE;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed cases plus random two-master traffic.
module tb_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m_rdata;
    logic        s_req, s_we, s_ack;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  grant;
    logic        timeout;

    bus_arbiter #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack),
        .m_rdata(m_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack),
        .grant(grant), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Slave model: memory with programmable or random wait states
    int          scnt = 0;
    int          rnd_lat = 0;
    int          fix_lat = 0;
    int          cur_lat;
    bit          use_rnd = 1'b0;
    bit          force_ack = 1'b0;
    logic [31:0] mem [0:127];

    assign cur_lat = use_rnd ? rnd_lat : fix_lat;
    assign s_ack   = (s_req && scnt == cur_lat) || force_ack;
    assign s_rdata = (s_ack && !s_we) ? mem[s_addr[8:2]] : 32'h0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            scnt <= 0;
        end else begin
            if (s_req && !s_ack) scnt <= scnt + 1;
            else scnt <= 0;
            if (s_req && s_ack) rnd_lat <= $urandom_range(0, 3);
            if (s_req && s_ack && s_we) mem[s_addr[8:2]] <= s_wdata;
        end
    end

    // Reference model: golden memory, per-master expected responses
    logic [31:0] gm [0:127];
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    int          ack_log [$];
    int          last_m = 1;
    bit          mon_en = 1'b0;

    task automatic gm_init();
        for (int i = 0; i < 128; i++) gm[i] = 32'h1000_0000 + 32'(i);
    endtask

    function automatic int exp_winner();
        return (RR && last_m == 0) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (m0_ack) begin
                if (exp0.size() == 0) check("m0_unexpected_ack", 32'd1, 32'd0);
                else check("m0_rdata", m_rdata, exp0.pop_front());
                ack_log.push_back(0);
                last_m = 0;
            end
            if (m1_ack) begin
                if (exp1.size() == 0) check("m1_unexpected_ack", 32'd1, 32'd0);
                else check("m1_rdata", m_rdata, exp1.pop_front());
                ack_log.push_back(1);
                last_m = 1;
            end
            if (!m0_ack && !m1_ack) check("rdata_zero_no_ack", m_rdata, 32'h0);
            if (s_req) begin
                if (grant == 2'b01) begin
                    check("s_we_m0", 32'(s_we), 32'(m0_we));
                    check("s_addr_m0", s_addr, m0_addr);
                    check("s_wdata_m0", s_wdata, m0_wdata);
                end else if (grant == 2'b10) begin
                    check("s_we_m1", 32'(s_we), 32'(m1_we));
                    check("s_addr_m1", s_addr, m1_addr);
                    check("s_wdata_m1", s_wdata, m1_wdata);
                end else begin
                    check("s_req_grant", 32'(grant), 32'd3);
                end
            end
        end
    end

    // Issue one transfer from master m; returns negedges until ack (IDLE cycle = 1)
    task automatic xfer(input int m, input bit we, input int idx,
                        input logic [31:0] wd, input bit tmo, output int cyc);
        logic [31:0] a;
        logic [31:0] e;
        logic        got;
        a = 32'(idx) << 2;
        e = tmo ? 32'hDEADBEEF : (we ? 32'h0 : gm[idx]);
        if (we && !tmo) gm[idx] = wd;
        if (m == 0) begin
            exp0.push_back(e);
            m0_we = we; m0_addr = a; m0_wdata = wd; m0_req = 1'b1;
        end else begin
            exp1.push_back(e);
            m1_we = we; m1_addr = a; m1_wdata = wd; m1_req = 1'b1;
        end
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            got = (m == 0) ? m0_ack : m1_ack;
        end
        if (!got) check("xfer_ack_bound", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (m == 0) m0_req = 1'b0;
        else m1_req = 1'b0;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    int          cyc, cyc2, nlog, w, l;
    logic [1:0]  gs [0:4];

    initial begin
        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        gm_init();
        #30;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_s_req", 32'(s_req), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_rdata", m_rdata, 32'h0);
        check("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
        sync();
        reset = 1'b0;
        mon_en = 1'b1;

        // M0 write with two wait states
        fix_lat = 2;
        fork
            xfer(0, 1'b1, 3, 32'hAABBCCDD, 1'b0, cyc);
            begin
                @(negedge clk);
                @(negedge clk);
                check("wr_grant_busy", 32'(grant), 32'd1);
                check("wr_s_addr", s_addr, 32'h0000000C);
                check("wr_s_wdata", s_wdata, 32'hAABBCCDD);
                check("wr_s_we", 32'(s_we), 32'd1);
            end
        join
        check("wr_latency", 32'(cyc), 32'd4);
        @(negedge clk);
        check("wr_ack_pulse", 32'(m0_ack), 32'd0);
        check("wr_grant_after", 32'(grant), 32'd0);
        sync();

        // Simultaneous reads, two rounds
        fix_lat = 0;
        xfer(0, 1'b1, 4, 32'h12345678, 1'b0, cyc);
        for (int r = 0; r < 2; r++) begin
            w = exp_winner();
            l = 1 - w;
            fork
                xfer(0, 1'b0, 4, 32'h0, 1'b0, cyc);
                xfer(1, 1'b0, 4, 32'h0, 1'b0, cyc2);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    gs[i] = grant;
                end
            join
            check("cont_g0", 32'(gs[0]), 32'd0);
            check("cont_g1_winner", 32'(gs[1]), (w == 0) ? 32'd1 : 32'd2);
            check("cont_g2_turnaround", 32'(gs[2]), 32'd0);
            check("cont_g3_loser", 32'(gs[3]), (l == 0) ? 32'd1 : 32'd2);
            nlog = ack_log.size();
            check("cont_order_first", 32'(ack_log[nlog-2]), 32'(w));
            check("cont_order_second", 32'(ack_log[nlog-1]), 32'(l));
            sync();
        end

        // s_ack on the terminal cycle is a normal completion
        fix_lat = 15;
        xfer(0, 1'b0, 5, 32'h0, 1'b0, cyc);
        check("term_ack_latency", 32'(cyc), 32'd17);
        check("term_no_timeout", 32'(timeout), 32'd0);

        // Slave never answers: abort on 16th busy cycle
        fix_lat = 1000;
        xfer(1, 1'b0, 40, 32'h0, 1'b1, cyc);
        check("tmo_latency", 32'(cyc), 32'd17);
        @(negedge clk);
        check("tmo_flag", 32'(timeout), 32'd1);
        sync();
        fix_lat = 0;
        xfer(1, 1'b1, 41, 32'h55AA55AA, 1'b0, cyc);
        xfer(0, 1'b0, 41, 32'h0, 1'b0, cyc);
        check("tmo_sticky", 32'(timeout), 32'd1);

        // Reset during the 3rd busy cycle of M1
        fix_lat = 1000;
        nlog = ack_log.size();
        m1_we = 1'b0; m1_addr = 32'h100; m1_req = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_mid_busy", 32'(s_req), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_s_req", 32'(s_req), 32'd0);
        check("rst_mid_grant", 32'(grant), 32'd0);
        check("rst_mid_ack", 32'(m1_ack), 32'd0);
        check("rst_mid_timeout", 32'(timeout), 32'd0);
        m1_req = 1'b0;
        gm_init();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        last_m = 1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", 32'({grant, s_req, m1_ack}), 32'd0);
        end
        check("post_rst_no_ack", 32'(ack_log.size()), 32'(nlog));
        sync();

        // M1 withdraws in the 2nd busy cycle, slave acks a cycle later
        m1_we = 1'b0; m1_addr = 32'h104; m1_req = 1'b1;
        sync();
        sync();
        m1_req = 1'b0;
        @(negedge clk);
        check("drop_s_req", 32'(s_req), 32'd0);
        check("drop_no_ack", 32'(m1_ack), 32'd0);
        sync();
        force_ack = 1'b1;
        @(negedge clk);
        check("late_ack_ignored", 32'(m1_ack), 32'd0);
        check("late_ack_idle", 32'(grant), 32'd0);
        sync();
        force_ack = 1'b0;
        check("drop_no_log", 32'(ack_log.size()), 32'(nlog));

        // Random traffic, disjoint address windows per master
        use_rnd = 1'b1;
        fork
            for (int k = 0; k < 30; k++) begin
                xfer(0, 1'($urandom_range(0, 1)), $urandom_range(0, 31),
                     $urandom, 1'b0, cyc);
                repeat ($urandom_range(0, 2)) sync();
            end
            for (int k = 0; k < 30; k++) begin
                xfer(1, 1'($urandom_range(0, 1)), $urandom_range(32, 63),
                     $urandom, 1'b0, cyc2);
                repeat ($urandom_range(0, 2)) sync();
            end
        join
        repeat (3) sync();
        check("sb_m0_drained", 32'(exp0.size()), 32'd0);
        check("sb_m1_drained", 32'(exp1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter
Overview:
Two-master, one-slave arbiter for the shared memory bus of the multi-cycle RISC-V system. It sits between the host debug command master (M0) and the CPU load/store/fetch port (M1) on one side, and the memory slave on the other. It serialises single transfers between the two masters and aborts hung transfers with a timeout.

Parameters:
ADDR_WIDTH, 32, width of m0_addr/m1_addr/s_addr.
TIMEOUT_CYCLES, 16, busy cycles without s_ack before abort; legal range 2..65535.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
m0_req  in  1  M0 (host debug) transfer request; held high until m0_ack.
m0_we  in  1  M0 write enable; 0 = read.
m0_addr  in  ADDR_WIDTH  M0 byte address.
m0_wdata  in  32  M0 write data.
m0_ack  out  1  one-cycle completion pulse to M0.
m1_req  in  1  M1 (CPU) transfer request; held high until m1_ack.
m1_we  in  1  M1 write enable.
m1_addr  in  ADDR_WIDTH  M1 byte address.
m1_wdata  in  32  M1 write data.
m1_ack  out  1  one-cycle completion pulse to M1.
m_rdata  out  32  read data, valid with the m0_ack or m1_ack pulse.
s_req  out  1  request to slave.
s_we  out  1  write enable to slave.
s_addr  out  ADDR_WIDTH  address to slave.
s_wdata  out  32  write data to slave.
s_rdata  in  32  slave read data, valid with s_ack.
s_ack  in  1  slave completion; may arrive in the first busy cycle.
grant  out  2  one-hot owner: 01 = M0, 10 = M1, 00 = none.
timeout  out  1  sticky flag: at least one transfer aborted; cleared only by reset.

Behaviour:
- Reset (asynchronous): state IDLE, grant=00, timeout=0, counter=0. All outputs 0.
- States: IDLE, BUSY_M0, BUSY_M1. The state register and grant are registered. The s_* outputs, m*_ack and m_rdata are combinational from the state and inputs.
- IDLE: requests are sampled. If any master requests, go to BUSY_x next cycle. Fixed priority: M0 wins. With no request, stay in IDLE.
- BUSY_x:
  - s_req=1; s_we/s_addr/s_wdata are muxed from the granted master.
  - m_rdata=s_rdata; mx_ack=s_ack in the same cycle.
  - On s_ack, go to IDLE.
- Latency and throughput: req in IDLE at cycle 0 gives s_req at cycle 1. A zero-wait slave gives mx_ack at cycle 1. There is always one IDLE turnaround cycle between transfers, so a master issuing back-to-back transfers gets at most 1 per 2 cycles.
- Timeout counter:
  - Clears on entry to BUSY and increments each busy cycle without s_ack.
  - When the count equals TIMEOUT_CYCLES-1 and s_ack=0: mx_ack=1, m_rdata=32'hDEADBEEF, timeout<=1, then go to IDLE.
  - s_ack on that same cycle takes precedence: it is a normal completion and timeout is not set.
- Master drops req while granted: s_req=0 that cycle, no ack, go to IDLE next cycle. A late s_ack is ignored.
- Ungranted master: ack stays 0 and its req is held pending.
- m_rdata=0 whenever no ack is pulsed.
- Reset mid-transfer: s_req and grant drop immediately and no ack is issued.

Optional Feature:
ARB_ROUND_ROBIN_EN:
- Defined: a last_grant register (reset value M1) picks the winner on a simultaneous request. The master not granted last wins.
- Undefined: fixed M0 priority; M1 can be starved by continuous M0 traffic.

Decomposition:
- Package bus_arbiter_pkg holds: the state enum (IDLE/BUSY_M0/BUSY_M1), grant encodings GRANT_NONE/GRANT_M0/GRANT_M1, and TIMEOUT_RDATA=32'hDEADBEEF.
- Sub-module arb_timeout_counter: clear, enable and terminal-count output; 16-bit width.

Test Plan:
- Reset 30 time units with both masters idle -> grant=00, s_req=0, timeout=0, m_rdata=0.
- M0 write, addr 0x0000000C, data 0xAABBCCDD, slave acks 2 cycles after s_req -> s_addr=0x0C, s_wdata=0xAABBCCDD, s_we=1, one-cycle m0_ack, grant 01 then 00.
- M0 and M1 both request reads in the same cycle, slave acks immediately with 0x12345678 -> M0 first, M1 granted after one IDLE cycle, each sees m_rdata=0x12345678. With ARB_ROUND_ROBIN_EN and continuous contention, grants alternate M0, M1, M0, M1.
- M1 read with slave never acking, TIMEOUT_CYCLES=16 -> m1_ack on the 16th busy cycle, m_rdata=0xDEADBEEF, timeout=1 and stays 1 across later good transfers.
- reset asserted in the 3rd BUSY_M1 cycle -> s_req, grant and m1_ack drop asynchronously; after release the state is IDLE with no spurious ack.
- M1 drops m1_req in the 2nd busy cycle, slave acks one cycle later -> no m1_ack, state IDLE, late s_ack ignored.
